// File: rtl/mem_collar_pkg.sv
// Shared types and helpers for the pmbist memory collars.
// Widths are capped by MAX_DATA_W / MAX_CNT_W so one definition serves every collar geometry.
package pmbist;

  localparam int MAX_READ_LAT = 3;
  localparam int MAX_DATA_W   = 64;
  localparam int MAX_DATA_AW  = 6;
  localparam int MAX_CNT_W    = 16;

  typedef struct packed {
    logic                 flag;
    logic [MAX_CNT_W-1:0] cnt;
  } collar_result_t;

  // Replicates a bg_w-bit background across the full word: bit i takes bg[i % bg_w].
  function automatic logic [MAX_DATA_W-1:0] bg_expand(input logic [MAX_DATA_W-1:0] bg,
                                                      input int bg_w);
    logic [MAX_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      r[i] = bg[MAX_DATA_AW'(i % bg_w)];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_collar_cmp_pipe.sv
// Read-compare alignment pipeline: READ_LAT stages of {valid, expected, address}, compared at the tail.
// The address stages only exist when MEM_COLLAR_FAIL_ADDR_EN is defined.
module mem_collar_cmp_pipe #(
  parameter int READ_LAT = 1,
  parameter int MEM_DATA = 7,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                ld_vld,
  input  logic [MEM_DATA-1:0] ld_exp,
`ifdef MEM_COLLAR_FAIL_ADDR_EN
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic [ADDR_W-1:0]   miscmp_addr,
`endif
  input  logic [MEM_DATA-1:0] q,
  output logic                miscmp
);

  logic                vld_q [READ_LAT];
  logic [MEM_DATA-1:0] exp_q [READ_LAT];
`ifdef MEM_COLLAR_FAIL_ADDR_EN
  logic [ADDR_W-1:0]   addr_q[READ_LAT];
`endif

  // Only the valid bits need clearing; payload stages are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int s = 0; s < READ_LAT; s++) vld_q[s] <= 1'b0;
    end else begin
      vld_q[0] <= ld_vld;
      for (int s = 1; s < READ_LAT; s++) vld_q[s] <= vld_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    exp_q[0] <= ld_exp;
    for (int s = 1; s < READ_LAT; s++) exp_q[s] <= exp_q[s-1];
`ifdef MEM_COLLAR_FAIL_ADDR_EN
    addr_q[0] <= ld_addr;
    for (int s = 1; s < READ_LAT; s++) addr_q[s] <= addr_q[s-1];
`endif
  end

  assign miscmp = vld_q[READ_LAT-1] && (q != exp_q[READ_LAT-1]);
`ifdef MEM_COLLAR_FAIL_ADDR_EN
  assign miscmp_addr = addr_q[READ_LAT-1];
`endif

endmodule

// File: rtl/mem_collar.sv
// BIST collar for one memory: test/functional mux, aligned compare, sticky results and serial result chain.
// Define MEM_COLLAR_FAIL_ADDR_EN to add the first-fail address register to the chain.
module mem_collar
  import pmbist::*;
#(
  parameter int ADR_X      = 2,
  parameter int ADR_Y      = 2,
  parameter int MEM_DATA   = 7,
  parameter int BG_DATA    = 2,
  parameter int READ_LAT   = 1,
  parameter int FAIL_CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mbist_run,
  input  logic [ADR_X-1:0]       addr_x,
  input  logic [ADR_Y-1:0]       addr_y,
  input  logic [BG_DATA-1:0]     bg_data,
  input  logic                   cs,
  input  logic                   we,
  input  logic                   odd_bwe,
  input  logic                   even_bwe,
  input  logic                   comp_en,
  input  logic [ADR_Y+ADR_X-1:0] func_addr,
  input  logic [MEM_DATA-1:0]    func_data,
  input  logic                   func_cs,
  input  logic                   func_we,
  output logic [ADR_Y+ADR_X-1:0] tomem_addr,
  output logic [MEM_DATA-1:0]    tomem_data,
  output logic [MEM_DATA-1:0]    tomem_bwe,
  output logic                   tomem_cs,
  output logic                   tomem_we,
  input  logic [MEM_DATA-1:0]    frommem_q,
  output logic                   fail_flag,
  input  logic                   shift_result,
  input  logic                   si,
  output logic                   so
);

  localparam int AW = ADR_Y + ADR_X;
`ifdef MEM_COLLAR_FAIL_ADDR_EN
  localparam int CHAIN_L = 1 + FAIL_CNT_W + AW;
`else
  localparam int CHAIN_L = 1 + FAIL_CNT_W;
`endif
  localparam logic [MAX_CNT_W-1:0] CNT_MAX = MAX_CNT_W'((1 << FAIL_CNT_W) - 1);

  logic [MEM_DATA-1:0] bg_exp;
  logic [MEM_DATA-1:0] bist_bwe;
  logic                run_q;
  logic                shift_q;
  logic                run_rise;
  logic                chain_ld;
  logic                chain_sh;
  logic                miscmp;
  logic [CHAIN_L-1:0]  chain_q;
  logic [CHAIN_L-1:0]  chain_src;
  collar_result_t      res_q;

  assign bg_exp = MEM_DATA'(bg_expand(MAX_DATA_W'(bg_data), BG_DATA));

  always_comb begin
    bist_bwe = '0;
    for (int i = 0; i < MEM_DATA; i++) bist_bwe[i] = (i % 2 == 1) ? odd_bwe : even_bwe;
  end

  always_comb begin
    if (mbist_run) begin
      tomem_addr = {addr_y, addr_x};
      tomem_data = bg_exp;
      tomem_bwe  = bist_bwe;
      tomem_cs   = cs;
      tomem_we   = we;
    end else begin
      tomem_addr = func_addr;
      tomem_data = func_data;
      tomem_bwe  = '1;
      tomem_cs   = func_cs;
      tomem_we   = func_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      run_q   <= mbist_run;
      shift_q <= shift_result;
    end
  end

  assign run_rise = mbist_run & ~run_q;
  assign chain_ld = shift_result & ~shift_q;
  assign chain_sh = shift_result & shift_q;

`ifdef MEM_COLLAR_FAIL_ADDR_EN
  logic [AW-1:0] miscmp_addr;
  logic [AW-1:0] ffa_q;
`endif

  mem_collar_cmp_pipe #(
    .READ_LAT(READ_LAT),
    .MEM_DATA(MEM_DATA),
    .ADDR_W  (AW)
  ) u_cmp_pipe (
    .clk        (clk),
    .rst        (rst),
    .clr        (run_rise),
    .ld_vld     (comp_en & cs & ~we & mbist_run),
    .ld_exp     (bg_exp),
`ifdef MEM_COLLAR_FAIL_ADDR_EN
    .ld_addr    ({addr_y, addr_x}),
    .miscmp_addr(miscmp_addr),
`endif
    .q          (frommem_q),
    .miscmp     (miscmp)
  );

  // A run start clears results even if a compare lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst || run_rise) begin
      res_q <= '0;
    end else if (miscmp) begin
      res_q.flag <= 1'b1;
      if (res_q.cnt != CNT_MAX) res_q.cnt <= res_q.cnt + MAX_CNT_W'(1);
    end
  end

`ifdef MEM_COLLAR_FAIL_ADDR_EN
  always_ff @(posedge clk) begin
    if (rst || run_rise) begin
      ffa_q <= '0;
    end else if (miscmp && !res_q.flag) begin
      ffa_q <= miscmp_addr;
    end
  end

  assign chain_src = {ffa_q, res_q.cnt[FAIL_CNT_W-1:0], res_q.flag};
`else
  assign chain_src = {res_q.cnt[FAIL_CNT_W-1:0], res_q.flag};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else if (chain_ld) begin
      chain_q <= chain_src;
    end else if (chain_sh) begin
      chain_q <= {si, chain_q[CHAIN_L-1:1]};
    end
  end

  assign so        = chain_q[0];
  assign fail_flag = res_q.flag;

endmodule

// File: tb/tb_mem_collar.sv
// Drives three collars (READ_LAT 1..3) in lockstep, each with its own memory model, against a word-level reference.
module tb_mem_collar;

  localparam int NI = 3;
`ifdef MEM_COLLAR_FAIL_ADDR_EN
  localparam int CL = 9;
`else
  localparam int CL = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mbist_run, cs, we, odd_bwe, even_bwe, comp_en;
  logic       func_cs, func_we, shift_result, si, stuck_en;
  logic [1:0] addr_x, addr_y, bg_data;
  logic [3:0] func_addr;
  logic [6:0] func_data;

  logic [3:0] t_addr[NI];
  logic [6:0] t_data[NI];
  logic [6:0] t_bwe [NI];
  logic [6:0] q     [NI];
  logic       t_cs  [NI];
  logic       t_we  [NI];
  logic       ff    [NI];
  logic       so    [NI];

  int total = 0;
  int bad   = 0;

  logic [6:0]    ref_mem[16];
  logic          ref_flag;
  logic [3:0]    ref_cnt;
  logic [3:0]    ref_ffa;
  logic [CL-1:0] got[NI];

  for (genvar g = 0; g < NI; g++) begin : inst
    logic [6:0] mem[16];
    logic [6:0] rdp[3];
    logic [6:0] rv;

    mem_collar #(.READ_LAT(g + 1)) dut (
      .clk(clk), .rst(rst), .mbist_run(mbist_run),
      .addr_x(addr_x), .addr_y(addr_y), .bg_data(bg_data),
      .cs(cs), .we(we), .odd_bwe(odd_bwe), .even_bwe(even_bwe), .comp_en(comp_en),
      .func_addr(func_addr), .func_data(func_data), .func_cs(func_cs), .func_we(func_we),
      .tomem_addr(t_addr[g]), .tomem_data(t_data[g]), .tomem_bwe(t_bwe[g]),
      .tomem_cs(t_cs[g]), .tomem_we(t_we[g]), .frommem_q(q[g]),
      .fail_flag(ff[g]), .shift_result(shift_result), .si(si), .so(so[g])
    );

    always_comb begin
      rv = mem[t_addr[g]];
      if (stuck_en && t_addr[g] == 4'h9) rv[3] = 1'b0;
    end

    // Synchronous memory with g+1 cycles of read latency.
    always @(posedge clk) begin
      if (rst) begin
        for (int a = 0; a < 16; a++) mem[a] <= '0;
      end else if (t_cs[g] && t_we[g]) begin
        mem[t_addr[g]] <= (mem[t_addr[g]] & ~t_bwe[g]) | (t_data[g] & t_bwe[g]);
      end
      if (t_cs[g] && !t_we[g]) rdp[0] <= rv;
      rdp[1] <= rdp[0];
      rdp[2] <= rdp[1];
    end

    assign q[g] = rdp[g];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] expand(input logic [1:0] bg);
    logic [6:0] w;
    for (int i = 0; i < 7; i++) w[i] = bg[i % 2];
    return w;
  endfunction

  task automatic ref_clear;
    ref_flag = 1'b0;
    ref_cnt  = '0;
    ref_ffa  = '0;
  endtask

  task automatic model_cmp(input logic [3:0] a, input logic [1:0] bg);
    logic [6:0] stored;
    stored = ref_mem[a];
    if (stuck_en && a == 4'h9) stored[3] = 1'b0;
    if (stored != expand(bg)) begin
      if (!ref_flag) ref_ffa = a;
      ref_flag = 1'b1;
      if (ref_cnt != 4'hF) ref_cnt = ref_cnt + 4'd1;
    end
  endtask

  task automatic start_run;
    mbist_run = 1'b0;
    cs = 1'b0; we = 1'b0; comp_en = 1'b0;
    tick();
    mbist_run = 1'b1;
    tick();
    ref_clear();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [1:0] bg, input logic ob, input logic eb);
    logic [6:0] mask;
    addr_y = a[3:2]; addr_x = a[1:0]; bg_data = bg;
    odd_bwe = ob; even_bwe = eb; cs = 1'b1; we = 1'b1; comp_en = 1'b0;
    tick();
    mask = (eb ? 7'b1010101 : 7'b0) | (ob ? 7'b0101010 : 7'b0);
    ref_mem[a] = (ref_mem[a] & ~mask) | (expand(bg) & mask);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [1:0] bg, input logic ce);
    addr_y = a[3:2]; addr_x = a[1:0]; bg_data = bg;
    cs = 1'b1; we = 1'b0; comp_en = ce;
    tick();
    if (ce) model_cmp(a, bg);
    cs = 1'b0; comp_en = 1'b0;
  endtask

  task automatic unload;
    shift_result = 1'b1;
    for (int k = 0; k < CL; k++) begin
      si = 1'($urandom);
      tick();
      for (int g = 0; g < NI; g++) got[g][k] = so[g];
    end
    shift_result = 1'b0;
    tick();
  endtask

  task automatic check_results(input string tag);
    logic [CL-1:0] exp_chain;
`ifdef MEM_COLLAR_FAIL_ADDR_EN
    exp_chain = {ref_ffa, ref_cnt, ref_flag};
`else
    exp_chain = {ref_cnt, ref_flag};
`endif
    for (int g = 0; g < NI; g++) chk($sformatf("%s_flag_lat%0d", tag, g + 1), 32'(ff[g]), 32'(ref_flag));
    unload();
    for (int g = 0; g < NI; g++) chk($sformatf("%s_chain_lat%0d", tag, g + 1), 32'(got[g]), 32'(exp_chain));
  endtask

  initial begin
    logic [1:0] bg;
    logic [6:0] fd;

    rst = 1'b1; mbist_run = 1'b0; cs = 1'b0; we = 1'b0; odd_bwe = 1'b0; even_bwe = 1'b0;
    comp_en = 1'b0; func_cs = 1'b0; func_we = 1'b0; shift_result = 1'b0; si = 1'b0;
    addr_x = '0; addr_y = '0; bg_data = '0; func_addr = '0; func_data = '0; stuck_en = 1'b0;
    for (int a = 0; a < 16; a++) ref_mem[a] = '0;
    ref_clear();
    tick();
    tick();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("reset_flag_lat%0d", g + 1), 32'(ff[g]), 32'd0);
      chk($sformatf("reset_so_lat%0d", g + 1), 32'(so[g]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Background expansion and odd/even enables in test mode.
    mbist_run = 1'b1; bg_data = 2'b01; odd_bwe = 1'b0; even_bwe = 1'b1;
    addr_y = 2'd2; addr_x = 2'd1; cs = 1'b1; we = 1'b1;
    #1;
    chk("bg_data", 32'(t_data[0]), 32'h55);
    chk("bg_bwe", 32'(t_bwe[0]), 32'h55);
    chk("bg_addr", 32'(t_addr[0]), 32'h9);
    chk("bg_cs_we", {30'd0, t_cs[0], t_we[0]}, 32'h3);
    for (int n = 0; n < 4; n++) begin
      bg = 2'($urandom); odd_bwe = 1'($urandom); even_bwe = 1'($urandom);
      bg_data = bg;
      #1;
      chk($sformatf("bg_rand_data%0d", n), 32'(t_data[2]), 32'(expand(bg)));
      chk($sformatf("bg_rand_bwe%0d", n), 32'(t_bwe[1]),
          32'((odd_bwe ? 7'b0101010 : 7'b0) | (even_bwe ? 7'b1010101 : 7'b0)));
    end
    cs = 1'b0; we = 1'b0;

    // Functional path.
    mbist_run = 1'b0; func_addr = 4'hA; func_we = 1'b1; func_cs = 1'b1;
    fd = 7'($urandom); func_data = fd;
    #1;
    chk("func_addr", 32'(t_addr[1]), 32'hA);
    chk("func_bwe", 32'(t_bwe[1]), 32'h7F);
    chk("func_data", 32'(t_data[1]), 32'(fd));
    chk("func_cs_we", {30'd0, t_cs[1], t_we[1]}, 32'h3);
    func_cs = 1'b0; func_we = 1'b0;
    tick();

    // Clean march passes.
    for (int p = 0; p < 2; p++) begin
      start_run();
      bg = 2'($urandom);
      for (int a = 0; a < 16; a++) do_write(4'(a), bg, 1'b1, 1'b1);
      for (int a = 0; a < 16; a++) do_read(4'(a), bg, 1'b1);
      repeat (4) tick();
      check_results($sformatf("march%0d", p));
    end

    // Stuck-at bit 3 at {y=2,x=1}: flag timing, then a full march.
    stuck_en = 1'b1;
    start_run();
    do_write(4'h9, 2'b10, 1'b1, 1'b1);
    do_read(4'h9, 2'b10, 1'b1);
    for (int g = 0; g < NI; g++) chk($sformatf("stuck_t0_lat%0d", g + 1), 32'(ff[g]), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      for (int g = 0; g < NI; g++)
        chk($sformatf("stuck_t%0d_lat%0d", k, g + 1), 32'(ff[g]), 32'(k >= g + 1));
    end
    for (int a = 0; a < 16; a++) do_write(4'(a), 2'b10, 1'b1, 1'b1);
    for (int a = 0; a < 16; a++) do_read(4'(a), 2'b10, 1'b1);
    repeat (4) tick();
    check_results("stuck");
    stuck_en = 1'b0;

    // Random writes (partial bit enables) and compared reads.
    start_run();
    for (int a = 0; a < 16; a++) do_write(4'(a), 2'($urandom), 1'b1, 1'b1);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) do_write(4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      else do_read(4'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (4) tick();
    check_results("random");

    // Counter saturation.
    start_run();
    for (int a = 0; a < 16; a++) do_write(4'(a), 2'b00, 1'b1, 1'b1);
    for (int n = 0; n < 20; n++) do_read(4'(n % 16), 2'b11, 1'b1);
    repeat (4) tick();
    check_results("saturate");

    // New run clears the results.
    start_run();
    for (int g = 0; g < NI; g++) chk($sformatf("newrun_flag_lat%0d", g + 1), 32'(ff[g]), 32'd0);
    check_results("newrun");

    // In-flight compare drains after mbist_run falls.
    do_write(4'h0, 2'b00, 1'b1, 1'b1);
    addr_y = 2'd0; addr_x = 2'd0; bg_data = 2'b11; cs = 1'b1; we = 1'b0; comp_en = 1'b1;
    tick();
    model_cmp(4'h0, 2'b11);
    mbist_run = 1'b0; cs = 1'b0; comp_en = 1'b0;
    repeat (4) tick();
    check_results("drain");

    // Reset mid-shift.
    shift_result = 1'b1;
    tick();
    for (int g = 0; g < NI; g++) chk($sformatf("shift_b0_lat%0d", g + 1), 32'(so[g]), 32'(ref_flag));
    tick();
    for (int g = 0; g < NI; g++) chk($sformatf("shift_b1_lat%0d", g + 1), 32'(so[g]), 32'(ref_cnt[0]));
    rst = 1'b1;
    tick();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_so_lat%0d", g + 1), 32'(so[g]), 32'd0);
      chk($sformatf("rst_flag_lat%0d", g + 1), 32'(ff[g]), 32'd0);
    end
    rst = 1'b0; shift_result = 1'b0;
    for (int a = 0; a < 16; a++) ref_mem[a] = '0;
    ref_clear();
    tick();
    check_results("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_collar.md
# mem_collar

Parametrised memory collar between the `pmbist_top` controller and one memory under test. It supersedes the fixed-geometry `mem_interface` and adds:
- background expansion and odd/even bit-write enables to any data width;
- a functional-path mux;
- compare alignment for memories with 1–3 cycles of read latency;
- sticky fail flag, saturating fail counter and optional first-fail address;
- a serial result chain that the controller shifts through its `si_to_mem`/`so_from_mem` loop.

## Interface
Parameters:
- `ADR_X`, 2, column address bits
- `ADR_Y`, 2, row address bits
- `MEM_DATA`, 7, memory word width
- `BG_DATA`, 2, controller background width; must be ≤ `MEM_DATA`
- `READ_LAT`, 1, memory read latency in cycles; legal range 1..3
- `FAIL_CNT_W`, 4, fail counter width

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `mbist_run`  in  1  test mode select; a 0→1 transition starts a new run
- `addr_x` / `addr_y`  in  `ADR_X` / `ADR_Y`  controller address
- `bg_data`  in  `BG_DATA`  controller background
- `cs`, `we`, `odd_bwe`, `even_bwe`, `comp_en`  in  1 each  controller strobes
- `func_addr`  in  `ADR_Y+ADR_X`  functional address
- `func_data`  in  `MEM_DATA`  functional write data
- `func_cs`, `func_we`  in  1 each  functional strobes
- `tomem_addr`  out  `ADR_Y+ADR_X`  memory address
- `tomem_data`  out  `MEM_DATA`  memory write data
- `tomem_bwe`  out  `MEM_DATA`  memory bit-write enables
- `tomem_cs`, `tomem_we`  out  1 each  memory strobes
- `frommem_q`  in  `MEM_DATA`  memory read data
- `fail_flag`  out  1  sticky fail
- `shift_result`  in  1  result chain load/shift enable
- `si`  in  1  chain serial in
- `so`  out  1  chain serial out

## Operation
- **Address/data mux (combinational):**
  - `mbist_run=1`: `tomem_addr={addr_y,addr_x}`, `tomem_cs=cs`, `tomem_we=we`.
  - `mbist_run=1`: `tomem_data[i]=bg_data[i % BG_DATA]`.
  - `mbist_run=1`: `tomem_bwe[i] = i odd ? odd_bwe : even_bwe`.
  - `mbist_run=0`: outputs are taken from `func_*`, and `tomem_bwe` is all ones.
- **Compare pipeline:**
  - `READ_LAT` stages, each holding valid, expected word and address.
  - A stage is loaded with valid=`comp_en & cs & ~we & mbist_run`.
  - At the last stage, valid with `frommem_q != expected` is a miscompare.
- **Result state on each miscompare:**
  - `fail_flag` is set.
  - `fail_cnt` increments and saturates at all-ones.
  - The first-fail address is captured only while `fail_flag` was 0.
- **New run:** a 0→1 edge of `mbist_run` clears the flag, counter, first-fail address and all pipeline valid bits.
- **Falling `mbist_run`:** compares already in flight drain and complete normally.
- **Result chain:**
  - Contents: `{first_fail_addr, fail_cnt, fail_flag}`, shifted LSB first, so `fail_flag` leaves first.
  - Rising edge of `shift_result` (1 now, 0 last cycle): parallel load.
  - Each later cycle with `shift_result=1`: shift right, with `si` entering the MSB.
  - `so` is chain bit 0.
  - If load and shift fall in the same cycle, load wins.
- **Simultaneous miscompare and run start:** the clear wins.

## Timing
- Reset values: `fail_flag=0`, `so=0`; chain, counter, address and pipeline valids are all 0.
- The `tomem_*` outputs are combinational from inputs and have no reset value.
- Compare latency, with `comp_en` sampled at edge E0 together with the memory read:
  - `frommem_q` is compared at edge E0+`READ_LAT`.
  - `fail_flag` is visible after that edge.
  - For `READ_LAT=1`, `comp_en` in cycle n gives `fail_flag` in cycle n+2.
- Chain length L = 1+`FAIL_CNT_W`(+`ADR_X+ADR_Y` with the macro). After the load edge, bit k appears on `so` k cycles later.
- `rst` asserted mid-run or mid-shift clears all state on the next edge.

## Configuration
- `MEM_COLLAR_FAIL_ADDR_EN`:
  - Defined: the first-fail address register exists and is prepended to the chain; the address is pipelined alongside the expected data.
  - Undefined: no address register and no address pipeline; L = 1+`FAIL_CNT_W`.

## Structure
- Shared package `pmbist` holds:
  - the `bg_expand` function (background replication);
  - `MAX_READ_LAT = 3`;
  - the `collar_result_t` packed struct (flag, count).
- Sub-module `mem_collar_cmp_pipe`: compare pipeline, parametrised by `READ_LAT`, `MEM_DATA` and address width.
- The result state and chain stay in `mem_collar`.

## Test plan
All scenarios use default parameters unless stated.
- **Background expansion:** `mbist_run=1`, `bg_data=2'b01`, `odd_bwe=0`, `even_bwe=1` -> `tomem_data=7'b1010101`, `tomem_bwe=7'b1010101`.
- **Functional mux:** `mbist_run=0`, `func_addr=4'hA`, `func_we=1` -> `tomem_addr=4'hA`, `tomem_bwe=7'h7F`.
- **March pass:** write then read all 16 addresses through the memory model with `READ_LAT` set to 1, 2 and 3 -> `fail_flag` stays 0 and a chain unload gives all zeros.
- **Stuck-at fault:** force memory bit 3 to 0 at address {y=2,x=1}, then run the pass and unload the chain with the macro defined -> `fail_flag` rises exactly `READ_LAT`+1 cycles after `comp_en`. The `so` sequence is 1, the count LSB-first, then address 4'b1001.
- **Counter saturation:** 20 miscompares -> `fail_cnt=4'hF`.
- **New-run clear:** a new `mbist_run` rise clears the counter to 0. A `rst` pulse mid-shift forces `so=0` on the next cycle.
